// File: rtl/axi_write_arbiter.sv
// Two-requester AXI write-path arbiter: round-robin AW into a registered stage, W steered in
// grant order via an order FIFO, B routed back by a source bit prepended to the master ID.
module axi_write_arbiter #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_aw_valid,
  output logic [1:0]                  req_aw_ready,
  input  logic [2*ADDR_WIDTH-1:0]     req_aw_addr,
  input  logic [2*ID_WIDTH-1:0]       req_aw_id,
  input  logic [15:0]                 req_aw_len,
  input  logic [5:0]                  req_aw_size,
  input  logic [1:0]                  req_w_valid,
  output logic [1:0]                  req_w_ready,
  input  logic [2*DATA_WIDTH-1:0]     req_w_data,
  input  logic [2*DATA_WIDTH/8-1:0]   req_w_strb,
  input  logic [1:0]                  req_w_last,
  output logic [1:0]                  req_b_valid,
  input  logic [1:0]                  req_b_ready,
  output logic [ID_WIDTH-1:0]         req_b_id,
  output logic [1:0]                  req_b_resp,
  output logic                        m_aw_valid,
  input  logic                        m_aw_ready,
  output logic [ADDR_WIDTH-1:0]       m_aw_addr,
  output logic [ID_WIDTH:0]           m_aw_id,
  output logic [7:0]                  m_aw_len,
  output logic [2:0]                  m_aw_size,
  output logic                        m_w_valid,
  input  logic                        m_w_ready,
  output logic [DATA_WIDTH-1:0]       m_w_data,
  output logic [DATA_WIDTH/8-1:0]     m_w_strb,
  output logic                        m_w_last,
  input  logic                        m_b_valid,
  output logic                        m_b_ready,
  input  logic [ID_WIDTH:0]           m_b_id,
  input  logic [1:0]                  m_b_resp,
  output logic                        idle
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(OUTSTANDING + 1);
  localparam int unsigned PtrW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic                   rr_q;
  logic [CntW-1:0]        cnt_q [2];
  logic [OUTSTANDING-1:0] ord_mem_q;
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]        ord_cnt_q;

  logic       stage_free, fifo_full, fifo_empty, grant_vld, grant, head, w_pop, b_src, b_hs;
  logic [1:0] elig;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Grants are suppressed during reset so no requester sees a phantom handshake.
  always_comb begin
    stage_free = !m_aw_valid || m_aw_ready;
    fifo_full  = (ord_cnt_q == CntW'(OUTSTANDING));
    fifo_empty = (ord_cnt_q == '0);
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_aw_valid[i] && !fifo_full && (cnt_q[i] < CntW'(OUTSTANDING));
    end
    grant_vld    = !rst && stage_free && (elig != 2'b00);
    grant        = (elig == 2'b11) ? rr_q : elig[1];
    req_aw_ready = '0;
    if (grant_vld) req_aw_ready[grant] = 1'b1;
  end

  assign head = ord_mem_q[rd_ptr_q];

  always_comb begin
    m_w_valid   = !fifo_empty && req_w_valid[head];
    m_w_data    = head ? req_w_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_w_data[DATA_WIDTH-1:0];
    m_w_strb    = head ? req_w_strb[2*StrbW-1:StrbW] : req_w_strb[StrbW-1:0];
    m_w_last    = head ? req_w_last[1] : req_w_last[0];
    req_w_ready = '0;
    if (!fifo_empty) req_w_ready[head] = m_w_ready;
  end

  assign w_pop = m_w_valid && m_w_ready && m_w_last;

  always_comb begin
    b_src              = m_b_id[ID_WIDTH];
    req_b_valid        = '0;
    req_b_valid[b_src] = m_b_valid && !rst;
    m_b_ready          = req_b_ready[b_src] && !rst;
    req_b_id           = m_b_id[ID_WIDTH-1:0];
    req_b_resp         = m_b_resp;
    b_hs               = m_b_valid && m_b_ready;
  end

  assign idle = !m_aw_valid && fifo_empty && (cnt_q[0] == '0) && (cnt_q[1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_aw_valid <= 1'b0;
      m_aw_addr  <= '0;
      m_aw_id    <= '0;
      m_aw_len   <= '0;
      m_aw_size  <= '0;
      rr_q       <= 1'b0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      ord_mem_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ord_cnt_q  <= '0;
    end else begin
      if (grant_vld) begin
        m_aw_valid <= 1'b1;
        m_aw_addr  <= grant ? req_aw_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_aw_addr[ADDR_WIDTH-1:0];
        m_aw_id    <= {grant, grant ? req_aw_id[2*ID_WIDTH-1:ID_WIDTH] : req_aw_id[ID_WIDTH-1:0]};
        m_aw_len   <= grant ? req_aw_len[15:8] : req_aw_len[7:0];
        m_aw_size  <= grant ? req_aw_size[5:3] : req_aw_size[2:0];
        rr_q       <= ~grant;
        ord_mem_q[wr_ptr_q] <= grant;
        wr_ptr_q   <= ptr_inc(wr_ptr_q);
      end else if (m_aw_ready) begin
        m_aw_valid <= 1'b0;
      end
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (grant_vld && !w_pop) begin
        ord_cnt_q <= ord_cnt_q + CntW'(1);
      end else if (w_pop && !grant_vld) begin
        ord_cnt_q <= ord_cnt_q - CntW'(1);
      end
      // A stray B on an idle requester is dropped rather than wrapping the counter.
      for (int i = 0; i < 2; i++) begin
        if (grant_vld && (grant == 1'(i)) &&
            !(b_hs && (b_src == 1'(i)) && (cnt_q[i] != '0))) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (b_hs && (b_src == 1'(i)) && (cnt_q[i] != '0) &&
                     !(grant_vld && (grant == 1'(i)))) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  b_without_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(b_hs && (cnt_q[b_src] == '0)));
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized bench for axi_write_arbiter: a driver acts as both requesters and the AXI slave,
// while a monitor checks the DUT against a transaction-level model and expected-value queues.
module tb_axi_write_arbiter;
  localparam int IW  = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int OUT = 4;

  typedef struct packed {logic [IW:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  typedef struct packed {logic [DW-1:0] data; logic [SW-1:0] strb; logic last;} w_t;
  typedef struct packed {logic src; w_t beat;} wb_t;
  typedef struct packed {logic [IW:0] id; logic [1:0] resp;} b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  logic [1:0]      req_aw_valid = '0, req_aw_ready;
  logic [2*AW-1:0] req_aw_addr = '0;
  logic [2*IW-1:0] req_aw_id = '0;
  logic [15:0]     req_aw_len = '0;
  logic [5:0]      req_aw_size = '0;
  logic [1:0]      req_w_valid = '0, req_w_ready;
  logic [2*DW-1:0] req_w_data = '0;
  logic [2*SW-1:0] req_w_strb = '0;
  logic [1:0]      req_w_last = '0;
  logic [1:0]      req_b_valid, req_b_ready = '0;
  logic [IW-1:0]   req_b_id;
  logic [1:0]      req_b_resp;
  logic            m_aw_valid, m_aw_ready = 1'b0;
  logic [AW-1:0]   m_aw_addr;
  logic [IW:0]     m_aw_id;
  logic [7:0]      m_aw_len;
  logic [2:0]      m_aw_size;
  logic            m_w_valid, m_w_ready = 1'b0;
  logic [DW-1:0]   m_w_data;
  logic [SW-1:0]   m_w_strb;
  logic            m_w_last;
  logic            m_b_valid = 1'b0, m_b_ready;
  logic [IW:0]     m_b_id = '0;
  logic [1:0]      m_b_resp = '0;
  logic            idle;

  axi_write_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUT)) dut (
    .clk(clk), .rst(rst),
    .req_aw_valid(req_aw_valid), .req_aw_ready(req_aw_ready), .req_aw_addr(req_aw_addr),
    .req_aw_id(req_aw_id), .req_aw_len(req_aw_len), .req_aw_size(req_aw_size),
    .req_w_valid(req_w_valid), .req_w_ready(req_w_ready), .req_w_data(req_w_data),
    .req_w_strb(req_w_strb), .req_w_last(req_w_last),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_id(req_b_id),
    .req_b_resp(req_b_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .idle(idle)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: got a transfer, required none pending", nm);
  endtask

  // Expected-value queues and driver bookkeeping
  aw_t         aw_exp[$];
  w_t          w_exp[$];
  b_t          b_exp[$];
  wb_t         wq[$];
  logic [IW:0] s_aw[$];
  logic [IW:0] b_pend[$];
  int          s_wdone = 0;
  logic [1:0]  hs_aw = '0, hs_w = '0;
  logic        hs_mb = 1'b0;
  int unsigned aw_pct = 70, wv_pct = 70, mawr_pct = 70, mw_pct = 70, br_pct = 70;
  bit          aw_en = 1'b1, b_en = 1'b1, first0 = 1'b1, drained = 1'b0, fin = 1'b0;

  function automatic int find_w(input logic s);
    for (int k = 0; k < wq.size(); k++) if (wq[k].src == s) return k;
    return -1;
  endfunction

  // Monitor: transaction-level model of grant order, outstanding counts and W order
  logic        mdl_stage, mdl_ptr;
  int          mdl_cnt [2];
  logic        mdl_ord[$];

  always @(negedge clk) begin
    logic [1:0] elig, exp_rdy, exp_wr;
    logic free, g, ev;
    aw_t ea;
    w_t ew;
    b_t eb;
    int s;
    if (rst) begin
      if (rst_q) begin
        chk("rst_m_aw_valid", m_aw_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_req_aw_ready", req_aw_ready, 2'b00);
        chk("rst_req_w_ready", req_w_ready, 2'b00);
        chk("rst_m_w_valid", m_w_valid, 1'b0);
        chk("rst_req_b_valid", req_b_valid, 2'b00);
        chk("rst_m_b_ready", m_b_ready, 1'b0);
      end
      mdl_stage = 1'b0;
      mdl_ptr = 1'b0;
      mdl_cnt[0] = 0;
      mdl_cnt[1] = 0;
      mdl_ord.delete();
    end else if (fin) begin
      chk("drain_complete", drained, 1'b1);
      chk("final_idle", idle, 1'b1);
    end else begin
      free = !mdl_stage || m_aw_ready;
      for (int i = 0; i < 2; i++)
        elig[i] = req_aw_valid[i] && (mdl_ord.size() < OUT) && (mdl_cnt[i] < OUT);
      exp_rdy = 2'b00;
      g = 1'b0;
      if (free && elig != 2'b00) begin
        g = (elig == 2'b11) ? mdl_ptr : elig[1];
        exp_rdy[g] = 1'b1;
      end
      chk("req_aw_ready", req_aw_ready, exp_rdy);
      chk("m_aw_valid", m_aw_valid, mdl_stage);
      chk("idle", idle, !mdl_stage && mdl_ord.size() == 0 && mdl_cnt[0] == 0 && mdl_cnt[1] == 0);
      ev = 1'b0;
      exp_wr = 2'b00;
      if (mdl_ord.size() > 0) begin
        ev = req_w_valid[mdl_ord[0]];
        exp_wr[mdl_ord[0]] = m_w_ready;
      end
      chk("m_w_valid", m_w_valid, ev);
      chk("req_w_ready", req_w_ready, exp_wr);
      // Staged AW is compared every cycle it is valid, so a stall must keep it stable.
      if (m_aw_valid) begin
        if (aw_exp.size() == 0) extra("m_aw_extra");
        else begin
          ea = aw_exp[0];
          chk("m_aw_id", m_aw_id, ea.id);
          chk("m_aw_addr", m_aw_addr, ea.addr);
          chk("m_aw_len", m_aw_len, ea.len);
          chk("m_aw_size", m_aw_size, ea.size);
          if (m_aw_ready) void'(aw_exp.pop_front());
        end
      end
      if (m_w_valid && m_w_ready) begin
        if (w_exp.size() == 0) extra("m_w_extra");
        else begin
          ew = w_exp.pop_front();
          chk("m_w_data", m_w_data, ew.data);
          chk("m_w_strb", m_w_strb, ew.strb);
          chk("m_w_last", m_w_last, ew.last);
        end
        if (m_w_last && mdl_ord.size() > 0) void'(mdl_ord.pop_front());
      end
      chk("req_b_valid", req_b_valid, m_b_valid ? (2'b01 << m_b_id[IW]) : 2'b00);
      chk("m_b_ready", m_b_ready, req_b_ready[m_b_id[IW]]);
      if (m_b_valid && m_b_ready) begin
        if (b_exp.size() == 0) extra("b_extra");
        else begin
          eb = b_exp.pop_front();
          chk("b_route", req_b_valid, 2'b01 << eb.id[IW]);
          chk("req_b_id", req_b_id, eb.id[IW-1:0]);
          chk("req_b_resp", req_b_resp, eb.resp);
        end
        s = int'(m_b_id[IW]);
        if (mdl_cnt[s] > 0) mdl_cnt[s]--;
      end
      if (exp_rdy != 2'b00) begin
        mdl_stage = 1'b1;
        mdl_ptr = ~g;
        mdl_cnt[g]++;
        mdl_ord.push_back(g);
      end else if (m_aw_ready) begin
        mdl_stage = 1'b0;
      end
    end
  end

  // One cycle of requester + slave behaviour: record handshakes, then drive new inputs.
  task automatic step();
    aw_t a;
    w_t bt;
    wb_t wb;
    int k;
    @(negedge clk);
    hs_aw = req_aw_valid & req_aw_ready;
    hs_w  = req_w_valid & req_w_ready;
    hs_mb = m_b_valid && m_b_ready;
    for (int i = 0; i < 2; i++) begin
      if (hs_aw[i]) begin
        a.id   = {i[0], req_aw_id[i*IW +: IW]};
        a.addr = req_aw_addr[i*AW +: AW];
        a.len  = req_aw_len[i*8 +: 8];
        a.size = req_aw_size[i*3 +: 3];
        aw_exp.push_back(a);
        for (int b = 0; b <= int'(a.len); b++) begin
          bt.data = {$urandom, $urandom};
          bt.strb = SW'($urandom);
          bt.last = (b == int'(a.len));
          w_exp.push_back(bt);
          wb.src = i[0];
          wb.beat = bt;
          wq.push_back(wb);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (hs_w[i]) begin
        k = find_w(i[0]);
        if (k >= 0) wq.delete(k);
      end
    end
    if (m_aw_valid && m_aw_ready) s_aw.push_back(m_aw_id);
    if (m_w_valid && m_w_ready && m_w_last) s_wdone++;
    while (s_aw.size() > 0 && s_wdone > 0) begin
      b_pend.push_back(s_aw.pop_front());
      s_wdone--;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!req_aw_valid[i] || hs_aw[i]) begin
        if (aw_en && $urandom_range(99) < aw_pct) begin
          req_aw_valid[i] = 1'b1;
          if (i == 0 && first0) begin
            req_aw_addr[AW-1:0] = 32'h8000_0040;
            req_aw_id[IW-1:0]   = 4'h3;
            req_aw_len[7:0]     = 8'd3;
            first0 = 1'b0;
          end else begin
            req_aw_addr[i*AW +: AW] = $urandom;
            req_aw_id[i*IW +: IW]   = IW'($urandom);
            req_aw_len[i*8 +: 8]    = 8'($urandom_range(3));
          end
          req_aw_size[i*3 +: 3] = 3'd3;
        end else begin
          req_aw_valid[i] = 1'b0;
        end
      end
      k = find_w(i[0]);
      if (k >= 0 && ((req_w_valid[i] && !hs_w[i]) || $urandom_range(99) < wv_pct)) begin
        req_w_valid[i] = 1'b1;
        req_w_data[i*DW +: DW] = wq[k].beat.data;
        req_w_strb[i*SW +: SW] = wq[k].beat.strb;
        req_w_last[i] = wq[k].beat.last;
      end else begin
        req_w_valid[i] = 1'b0;
      end
      req_b_ready[i] = ($urandom_range(99) < br_pct);
    end
    m_aw_ready = ($urandom_range(99) < mawr_pct);
    m_w_ready  = ($urandom_range(99) < mw_pct);
    if (!(m_b_valid && !hs_mb)) begin
      if (b_en && b_pend.size() > 0 && $urandom_range(99) < 70) begin
        m_b_valid = 1'b1;
        m_b_id    = b_pend.pop_front();
        m_b_resp  = 2'($urandom);
        b_exp.push_back({m_b_id, m_b_resp});
      end else begin
        m_b_valid = 1'b0;
      end
    end
  endtask

  // Reset with every input busy, then release with W valid but no AW outstanding.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_aw_valid = 2'b11;
    req_w_valid = 2'b11;
    m_b_valid = 1'b1;
    m_b_id = 5'h13;
    req_b_ready = 2'b11;
    m_aw_ready = 1'b0;
    m_w_ready = 1'b1;
    aw_exp.delete(); w_exp.delete(); b_exp.delete(); wq.delete();
    s_aw.delete(); b_pend.delete();
    s_wdone = 0;
    hs_aw = '0; hs_w = '0; hs_mb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_aw_valid = 2'b00;
    m_b_valid = 1'b0;
    req_b_ready = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;
    req_w_valid = 2'b00;
  endtask

  task automatic set_pct(input int unsigned aw, input int unsigned rdy);
    aw_pct = aw; wv_pct = rdy; mawr_pct = rdy; mw_pct = rdy; br_pct = rdy;
  endtask

  initial begin
    do_reset();
    set_pct(100, 100);
    repeat (80) step();
    set_pct(70, 70);
    repeat (1500) step();
    b_en = 1'b0;
    set_pct(100, 80);
    repeat (150) step();
    b_en = 1'b1;
    set_pct(60, 60);
    repeat (200) step();
    do_reset();
    repeat (500) step();
    aw_en = 1'b0;
    set_pct(0, 100);
    for (int k = 0; k < 3000 && !drained; k++) begin
      step();
      drained = aw_exp.size() == 0 && w_exp.size() == 0 && wq.size() == 0 && b_exp.size() == 0 &&
                b_pend.size() == 0 && s_aw.size() == 0 && req_aw_valid == 2'b00 && !m_b_valid;
    end
    fin = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
